// File: rtl/uart_z_pkg.sv
// uart_z_pkg: shared FSM states, default acknowledge bytes and bit-time counter sizing
// for the UART acknowledge transmitter.
package uart_z_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;

    localparam logic [7:0] NAK_BYTE_DEF = 8'h4E;
    localparam logic [7:0] ACK_BASE_DEF = 8'h30;

    function automatic int cnt_width(input int baud_div);
        return (baud_div < 2) ? 1 : $clog2(baud_div);
    endfunction

endpackage

// File: rtl/uart_flag_ack_tx_if.sv
// uart_flag_ack_tx_if: receive-complete request in, serial acknowledge line and status out.
interface uart_flag_ack_tx_if;

    logic       over_rx;
    logic [1:0] flag;
    logic       tx;
    logic       busy;
    logic       drop;

    modport master (output over_rx, flag, input tx, busy, drop);
    modport slave  (input over_rx, flag, output tx, busy, drop);

endinterface

// File: rtl/uart_tx_baud_z.sv
// uart_tx_baud_z: free-running bit-time counter; tick is high in the last cycle of each bit.
module uart_tx_baud_z
    import uart_z_pkg::*;
#(
    parameter int BAUD_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int W = cnt_width(BAUD_DIV);

    logic [W-1:0] r_cnt;

    assign tick = (r_cnt == W'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= (clear || tick) ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_flag_ack_tx.sv
// uart_flag_ack_tx: sends a one-byte ACK/NAK per receive-complete edge, with one pending slot.
// Define UART_ACK_PARITY_EN for 8E1 frames; default is 8N1.
module uart_flag_ack_tx
    import uart_z_pkg::*;
#(
    parameter int         CLK_FREQ = 50_000_000,
    parameter int         BAUD     = 9600,
    parameter logic [7:0] ACK_BASE = ACK_BASE_DEF,
    parameter logic [7:0] NAK_BYTE = NAK_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_flag_ack_tx_if.slave bus
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;

    state_t     r_state;
    logic       r_over_q;
    logic       r_pend_vld;
    logic [7:0] r_pend_byte;
    logic [7:0] r_shift;
    logic [2:0] r_bit;
    logic       r_tx;
    logic       r_drop;
`ifdef UART_ACK_PARITY_EN
    logic       r_par;
`endif
    logic       w_req;
    logic       w_pop;
    logic       w_tick;
    logic [7:0] w_byte;

    // r_over_q resets high so a line already high out of reset is not a request
    assign w_req  = bus.over_rx & ~r_over_q;
    assign w_pop  = (r_state == IDLE) & r_pend_vld;
    assign w_byte = (bus.flag == 2'b00) ? NAK_BYTE : ACK_BASE + 8'(bus.flag);

    uart_tx_baud_z #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_pop),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_over_q    <= 1'b1;
            r_pend_vld  <= 1'b0;
            r_pend_byte <= '0;
            r_drop      <= 1'b0;
        end else begin
            r_over_q <= bus.over_rx;
            r_drop   <= w_req & r_pend_vld & ~w_pop;
            if (w_req && (w_pop || !r_pend_vld)) begin
                r_pend_vld  <= 1'b1;
                r_pend_byte <= w_byte;
            end else if (w_pop) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_shift <= '0;
            r_bit   <= '0;
`ifdef UART_ACK_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (r_pend_vld) begin
                        r_shift <= r_pend_byte;
                        r_bit   <= '0;
                        r_tx    <= 1'b0;
                        r_state <= START;
`ifdef UART_ACK_PARITY_EN
                        r_par   <= ^r_pend_byte;
`endif
                    end
                end
                START: if (w_tick) begin
                    r_tx    <= r_shift[0];
                    r_shift <= r_shift >> 1;
                    r_state <= DATA;
                end
                DATA: if (w_tick) begin
                    r_bit <= r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef UART_ACK_PARITY_EN
                        r_tx    <= r_par;
                        r_state <= PARITY;
`else
                        r_tx    <= 1'b1;
                        r_state <= STOP;
`endif
                    end else begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
`ifdef UART_ACK_PARITY_EN
                PARITY: if (w_tick) begin
                    r_tx    <= 1'b1;
                    r_state <= STOP;
                end
`endif
                STOP: if (w_tick) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.tx   = r_tx;
    assign bus.busy = (r_state != IDLE) | r_pend_vld;
    assign bus.drop = r_drop;

endmodule

// File: tb/tb_uart_flag_ack_tx.sv
// tb_uart_flag_ack_tx: table-driven byte checks, directed corner sequences and a
// randomized run against a frame-timeline reference model.
module tb_uart_flag_ack_tx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_ACK_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int F = NBITS * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_flag_ack_tx_if bus();

    uart_flag_ack_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] fl;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t tbl [4];

    int n_vec = 0;
    int n_err = 0;
    int k     = 0;
    int d_cnt = 0;

    // reference model: one pending slot plus the currently transmitting frame
    logic       m_prev, m_pvld, m_have;
    logic [7:0] m_pbyte, m_fbyte;
    int         m_fs;

    logic tx_s, busy_s, drop_s;
    logic rtx   [F+1];
    logic rbusy [F+1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [1:0] fl);
        return (fl == 2'b00) ? 8'h4E : 8'h30 + 8'(fl);
    endfunction

    // line level at offset o cycles into a frame carrying byte b
    function automatic logic bit_at(input int o, input logic [7:0] b);
        int i;
        i = o / DIV;
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9 && NBITS == 11) return ^b;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_prev = 1'b1;
        m_pvld = 1'b0;
        m_have = 1'b0;
    endtask

    task automatic step(input logic ov, input logic [1:0] fl);
        logic req, pop, act, etx, ebusy, edrop;
        bus.over_rx = ov;
        bus.flag    = fl;
        @(posedge clk);
        #1;
        k++;
        req    = ov & ~m_prev;
        m_prev = ov;
        pop    = m_pvld && (!m_have || (k - 1 >= m_fs + F));
        if (pop) begin
            m_have  = 1'b1;
            m_fs    = k;
            m_fbyte = m_pbyte;
            m_pvld  = 1'b0;
        end
        edrop = req & m_pvld;
        if (req && !m_pvld) begin
            m_pvld  = 1'b1;
            m_pbyte = byte_of(fl);
        end
        act   = m_have && (k < m_fs + F);
        etx   = act ? bit_at(k - m_fs, m_fbyte) : 1'b1;
        ebusy = act | m_pvld;
        tx_s   = bus.tx;
        busy_s = bus.busy;
        drop_s = bus.drop;
        d_cnt += int'(drop_s);
        check("cycle {tx,busy,drop}", {29'd0, tx_s, busy_s, drop_s}, {29'd0, etx, ebusy, edrop});
    endtask

    task automatic run_until_idle(input int limit, output int end_k);
        end_k = -1;
        for (int i = 0; i < limit; i++) begin
            step(1'b0, 2'b00);
            if (!busy_s) begin
                end_k = k;
                break;
            end
        end
    endtask

    initial begin
        int e0, ek, d0, bl, bcnt, gap;
        logic [7:0] got;
        logic ov;

        tbl[0] = '{2'b00, 8'h4E};
        tbl[1] = '{2'b01, 8'h31};
        tbl[2] = '{2'b10, 8'h32};
        tbl[3] = '{2'b11, 8'h33};

        bus.over_rx = 1'b0;
        bus.flag    = 2'b00;
        #12;
        check("reset tx", bus.tx, 1);
        check("reset busy", bus.busy, 0);
        check("reset drop", bus.drop, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int t = 0; t < 4; t++) begin
            repeat (3) step(1'b0, 2'b00);
            step(1'b1, tbl[t].fl);
            check("tx high at sample edge", tx_s, 1);
            for (int i = 0; i <= F; i++) begin
                step(1'b0, 2'b00);
                rtx[i]   = tx_s;
                rbusy[i] = busy_s;
            end
            got = '0;
            for (int b = 0; b < 8; b++) got[b] = rtx[DIV * (b + 1) + DIV / 2];
            check("frame byte", got, tbl[t].exp_byte);
            check("tx fall one cycle after sample", rtx[0], 0);
            check("stop bit", rtx[(NBITS - 1) * DIV + DIV / 2], 1);
`ifdef UART_ACK_PARITY_EN
            check("parity bit", rtx[9 * DIV + DIV / 2], ^tbl[t].exp_byte);
`endif
            bl = -1;
            for (int i = 0; i <= F; i++) if (!rbusy[i] && bl < 0) bl = i;
            check("busy length after fall", bl, F);
        end

        // second request during frame A is held and follows after one idle cycle
        repeat (5) step(1'b0, 2'b00);
        d0 = d_cnt;
        step(1'b1, 2'b01);
        e0 = k;
        repeat (19) step(1'b0, 2'b00);
        step(1'b1, 2'b11);
        run_until_idle(4 * F, ek);
        check("back-to-back duration", ek - e0, 2 * F + 2);
        check("back-to-back drops", d_cnt - d0, 0);

        // third request while pending is full is dropped
        repeat (5) step(1'b0, 2'b00);
        d0 = d_cnt;
        step(1'b1, 2'b01);
        e0 = k;
        repeat (19) step(1'b0, 2'b00);
        step(1'b1, 2'b10);
        repeat (19) step(1'b0, 2'b00);
        step(1'b1, 2'b11);
        check("drop pulse on third request", drop_s, 1);
        run_until_idle(4 * F, ek);
        check("three-request duration", ek - e0, 2 * F + 2);
        check("three-request drops", d_cnt - d0, 1);

        // reset in the middle of DATA, over_rx held high through release
        repeat (5) step(1'b0, 2'b00);
        step(1'b1, 2'b10);
        repeat (30) step(1'b0, 2'b00);
        bus.over_rx = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("mid-frame reset tx", bus.tx, 1);
        check("mid-frame reset busy", bus.busy, 0);
        check("mid-frame reset drop", bus.drop, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        bcnt = 0;
        repeat (150) begin
            step(1'b1, 2'b11);
            bcnt += int'(busy_s);
        end
        check("no frame after reset release", bcnt, 0);

        // randomized traffic with varying request density
        ov = 1'b1;
        for (int s = 0; s < 8; s++) begin
            gap = $urandom_range(2, 80);
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, gap) == 0) ov = ~ov;
                step(ov, 2'($urandom));
            end
        end
        run_until_idle(4 * F, ek);
        check("final drain", ek > 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
